// File: rtl/rr_pkg.sv
// Shared types and constants for the round-robin packet mux data stage.
package rr_pkg;

  typedef enum logic {ST_IDLE, ST_LOCKED} rr_state_t;

  localparam logic [1:0] RR_DEPTH = 2'd2;

endpackage

// File: rtl/rr_skid_fifo.sv
// Two-entry synchronous FIFO; push is dropped when full, pop when empty.
module rr_skid_fifo
  import rr_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push_ok_s = i_push & (count_r != RR_DEPTH);
  assign pop_ok_s  = i_pop & (count_r != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= i_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign o_data  = (count_r != 2'd0) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign o_count = count_r;

endmodule

// File: rtl/rr_packet_mux.sv
// Steers the granted master's packet into a 2-entry buffer toward the slave,
// holding the grant until the last beat and then pulsing o_grant_adv.
module rr_packet_mux
  import rr_pkg::*;
#(
  parameter  int PORTS_N = 3,
  parameter  int DATA_W  = 32,
  localparam int PORTS_W = $clog2(PORTS_N)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_grant_valid,
  input  logic [PORTS_W-1:0] i_grant_idx,
  output logic               o_grant_adv,
  input  logic [PORTS_N-1:0] i_master_valid,
  input  logic [DATA_W-1:0]  i_master_data [PORTS_N],
  input  logic [PORTS_N-1:0] i_master_last,
  output logic [PORTS_N-1:0] o_master_ready,
  output logic               o_slave_valid,
  output logic [DATA_W-1:0]  o_slave_data,
  output logic               o_slave_last,
  input  logic               i_slave_ready,
  output logic               o_busy
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } rr_beat_t;

  localparam logic [PORTS_W:0] PORTS_N_L = (PORTS_W + 1)'(PORTS_N);

  rr_state_t          state_r;
  logic [PORTS_W-1:0] lock_idx_r;
  logic               grant_adv_r;
  logic               sel_valid_s;
  logic [PORTS_W-1:0] sel_idx_s;
  logic [PORTS_N-1:0] master_ready_s;
  logic               push_s;
  logic               push_last_s;
  logic               pop_s;
  logic [1:0]         count_s;
  rr_beat_t           push_beat_s;
  rr_beat_t           head_beat_s;

  // Port selection: the lock owns the mux; otherwise an in-range grant does.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = {PORTS_W{1'b0}};
    if (state_r == ST_LOCKED) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = lock_idx_r;
    end else if (i_grant_valid && ({1'b0, i_grant_idx} < PORTS_N_L)) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = i_grant_idx;
    end else begin
      sel_valid_s = 1'b0;
      sel_idx_s   = {PORTS_W{1'b0}};
    end
  end

  // One-hot ready decode from registered occupancy, independent of valid.
  always_comb begin
    master_ready_s = {PORTS_N{1'b0}};
    if (sel_valid_s && (count_s < RR_DEPTH)) begin
      master_ready_s[sel_idx_s] = 1'b1;
    end else begin
      master_ready_s = {PORTS_N{1'b0}};
    end
  end

  assign push_s           = sel_valid_s & (count_s < RR_DEPTH) & i_master_valid[sel_idx_s];
  assign push_last_s      = i_master_last[sel_idx_s];
  assign push_beat_s.data = i_master_data[sel_idx_s];
  assign push_beat_s.last = push_last_s;
  assign pop_s            = o_slave_valid & i_slave_ready;

  rr_skid_fifo #(
    .WIDTH ($bits(rr_beat_t))
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_s),
    .i_pop     (pop_s),
    .i_data    (push_beat_s),
    .o_data    (head_beat_s),
    .o_count   (count_s)
  );

  // Packet lock FSM with registered grant-advance pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      lock_idx_r  <= {PORTS_W{1'b0}};
      grant_adv_r <= 1'b0;
    end else begin
      grant_adv_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (push_s) begin
            if (push_last_s) begin
              grant_adv_r <= 1'b1;
            end else begin
              state_r    <= ST_LOCKED;
              lock_idx_r <= i_grant_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (push_s && push_last_s) begin
            state_r     <= ST_IDLE;
            grant_adv_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_master_ready = master_ready_s;
  assign o_grant_adv    = grant_adv_r;
  assign o_slave_valid  = (count_s != 2'd0);
  assign o_slave_data   = head_beat_s.data;
  assign o_slave_last   = head_beat_s.last;
  assign o_busy         = (state_r == ST_LOCKED) | (count_s != 2'd0);

endmodule
